present_sbox_serial: RTL

//   Area-optimised PRESENT substitution layer: applies the 4-bit PRESENT S-box to all
//   16 nibbles of a 64-bit state, NIB_PER_CYC nibbles per clock. Sits directly upstream
//   of the 64-bit bit-permutation layer and drives it with a valid/ready handshake.

---
 rtl/present_sbox_serial.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/present_sbox_serial.sv
// Serial PRESENT substitution layer: NIB_PER_CYC nibbles per clock over a 64-bit state.
// Define PRESENT_SBOX_INV_EN to add the in_inv port and the inverse S-box table.
module present_sbox_serial #(
  parameter int unsigned NIB_PER_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_dat,
`ifdef PRESENT_SBOX_INV_EN
  input  logic        in_inv,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_dat,
  output logic        busy
);

  localparam int unsigned N  = 16 / NIB_PER_CYC;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (NIB_PER_CYC != 1 && NIB_PER_CYC != 2 && NIB_PER_CYC != 4 &&
      NIB_PER_CYC != 8 && NIB_PER_CYC != 16) begin : g_bad_nib_per_cyc
    $error("present_sbox_serial: NIB_PER_CYC must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE,
    SUBST,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   work_q, work_d;
  logic [63:0]   sub;
  logic          out_valid_q, out_valid_d;
  logic          inv;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    case (x)
      4'h0: sbox_fwd = 4'hC;  4'h1: sbox_fwd = 4'h5;
      4'h2: sbox_fwd = 4'h6;  4'h3: sbox_fwd = 4'hB;
      4'h4: sbox_fwd = 4'h9;  4'h5: sbox_fwd = 4'h0;
      4'h6: sbox_fwd = 4'hA;  4'h7: sbox_fwd = 4'hD;
      4'h8: sbox_fwd = 4'h3;  4'h9: sbox_fwd = 4'hE;
      4'hA: sbox_fwd = 4'hF;  4'hB: sbox_fwd = 4'h8;
      4'hC: sbox_fwd = 4'h4;  4'hD: sbox_fwd = 4'h7;
      4'hE: sbox_fwd = 4'h1;  default: sbox_fwd = 4'h2;
    endcase
  endfunction

`ifdef PRESENT_SBOX_INV_EN
  logic inv_q, inv_d;

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;
      4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;
      4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;
      4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;
      4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  assign inv = inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end

  always_comb begin
    inv_d = inv_q;
    if (state_q == IDLE && in_valid) inv_d = in_inv;
  end
`else
  assign inv = 1'b0;
`endif

  // Only the nibble slice selected by the counter is rewritten; the rest pass through.
  always_comb begin
    int unsigned idx;
    sub = work_q;
    for (int unsigned j = 0; j < NIB_PER_CYC; j++) begin
      idx = int'(cnt_q) * NIB_PER_CYC + j;
`ifdef PRESENT_SBOX_INV_EN
      sub[idx*4 +: 4] = inv ? sbox_inv(work_q[idx*4 +: 4]) : sbox_fwd(work_q[idx*4 +: 4]);
`else
      sub[idx*4 +: 4] = sbox_fwd(work_q[idx*4 +: 4]);
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_dat;
          cnt_d   = '0;
          state_d = SUBST;
        end
      end
      SUBST: begin
        work_d = sub;
        if (cnt_q == CW'(N - 1)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_dat   = work_q;

endmodule
